// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-execute bundle between the ID stage, the ID/EX register and EX
// Stat ports exist only when ID_EX_STATS_EN is defined.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
);
  logic              id_valid_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [4:0]        id_rs1_i;
  logic [4:0]        id_rs2_i;
  logic [4:0]        id_rd_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [XLEN-1:0]   id_rdata1_i;
  logic [XLEN-1:0]   id_rdata2_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              flush_i;
  logic              hold_i;

  logic              stall_o;
  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_pc_o;
  logic [4:0]        ex_rs1_o;
  logic [4:0]        ex_rs2_o;
  logic [4:0]        ex_rd_o;
  logic [XLEN-1:0]   ex_rdata1_o;
  logic [XLEN-1:0]   ex_rdata2_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
`ifdef ID_EX_STATS_EN
  logic [31:0]       stat_stall_o;
  logic [31:0]       stat_bubble_o;
  logic [31:0]       stat_flush_o;
`endif

  modport master (
    output id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_use_rs1_i, id_use_rs2_i, id_rdata1_i, id_rdata2_i,
           id_imm_i, id_ctrl_i, flush_i, hold_i,
    input  stall_o, ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
           ex_rdata1_o, ex_rdata2_o, ex_imm_o, ex_ctrl_o
`ifdef ID_EX_STATS_EN
    , input stat_stall_o, stat_bubble_o, stat_flush_o
`endif
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_use_rs1_i, id_use_rs2_i, id_rdata1_i, id_rdata2_i,
           id_imm_i, id_ctrl_i, flush_i, hold_i,
    output stall_o, ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
           ex_rdata1_o, ex_rdata2_o, ex_imm_o, ex_ctrl_o
`ifdef ID_EX_STATS_EN
    , output stat_stall_o, stat_bubble_o, stat_flush_o
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection, flush and hold
// Optional saturating stall/bubble/flush counters are built when ID_EX_STATS_EN is defined.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  localparam int CTRL_MEM_READ = 1;

  logic              ex_valid_q;
  logic [XLEN-1:0]   ex_pc_q;
  logic [4:0]        ex_rs1_q;
  logic [4:0]        ex_rs2_q;
  logic [4:0]        ex_rd_q;
  logic [XLEN-1:0]   ex_rdata1_q;
  logic [XLEN-1:0]   ex_rdata2_q;
  logic [XLEN-1:0]   ex_imm_q;
  logic [CTRL_W-1:0] ex_ctrl_q;

  logic rs1_dep;
  logic rs2_dep;
  logic lu;
  logic stall;
  logic bubble_load;

  // Load in EX whose (non-x0) destination is a real source of the ID instruction.
  assign rs1_dep = bus.id_use_rs1_i && (bus.id_rs1_i == ex_rd_q);
  assign rs2_dep = bus.id_use_rs2_i && (bus.id_rs2_i == ex_rd_q);
  assign lu      = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && (ex_rd_q != 5'd0) &&
                   bus.id_valid_i && (rs1_dep || rs2_dep);

  assign stall       = !rst && !bus.flush_i && (bus.hold_i || lu);
  assign bubble_load = !rst && !bus.flush_i && !bus.hold_i && lu;

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i || bubble_load) begin
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      ex_rdata1_q <= '0;
      ex_rdata2_q <= '0;
      ex_imm_q    <= '0;
      ex_ctrl_q   <= '0;
    end else if (!bus.hold_i) begin
      ex_valid_q  <= bus.id_valid_i;
      ex_pc_q     <= bus.id_pc_i;
      ex_rs1_q    <= bus.id_rs1_i;
      ex_rs2_q    <= bus.id_rs2_i;
      ex_rd_q     <= bus.id_rd_i;
      ex_rdata1_q <= bus.id_rdata1_i;
      ex_rdata2_q <= bus.id_rdata2_i;
      ex_imm_q    <= bus.id_imm_i;
      ex_ctrl_q   <= bus.id_valid_i ? bus.id_ctrl_i : '0;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.ex_valid_o  = ex_valid_q;
  assign bus.ex_pc_o     = ex_pc_q;
  assign bus.ex_rs1_o    = ex_rs1_q;
  assign bus.ex_rs2_o    = ex_rs2_q;
  assign bus.ex_rd_o     = ex_rd_q;
  assign bus.ex_rdata1_o = ex_rdata1_q;
  assign bus.ex_rdata2_o = ex_rdata2_q;
  assign bus.ex_imm_o    = ex_imm_q;
  assign bus.ex_ctrl_o   = ex_ctrl_q;

`ifdef ID_EX_STATS_EN
  logic [31:0] stat_stall_q;
  logic [31:0] stat_bubble_q;
  logic [31:0] stat_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_q  <= '0;
      stat_bubble_q <= '0;
      stat_flush_q  <= '0;
    end else begin
      if (stall && (stat_stall_q != 32'hFFFF_FFFF))
        stat_stall_q <= stat_stall_q + 32'd1;
      if (bubble_load && (stat_bubble_q != 32'hFFFF_FFFF))
        stat_bubble_q <= stat_bubble_q + 32'd1;
      if (bus.flush_i && (stat_flush_q != 32'hFFFF_FFFF))
        stat_flush_q <= stat_flush_q + 32'd1;
    end
  end

  assign bus.stat_stall_o  = stat_stall_q;
  assign bus.stat_bubble_o = stat_bubble_q;
  assign bus.stat_flush_o  = stat_flush_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against a behavioural model
// Counter checks are compiled in only when ID_EX_STATS_EN is defined.
module tb_id_ex_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  id_ex_stage_if #(.XLEN(32), .CTRL_W(8)) bus ();
  id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [7:0]  ctrl;
  } ex_t;

  ex_t         m;
  logic [31:0] m_stall, m_bubble, m_flush;

  localparam logic [7:0] C_ALU = 8'h01;
  localparam logic [7:0] C_LW  = 8'h1B;

  function automatic ex_t dut_ex();
    return {bus.ex_valid_o, bus.ex_pc_o, bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_rd_o,
            bus.ex_rdata1_o, bus.ex_rdata2_o, bus.ex_imm_o, bus.ex_ctrl_o};
  endfunction

  // A load sitting in EX that writes a register the ID instruction really reads.
  function automatic logic model_lu();
    return m.v && m.ctrl[1] && (m.rd != 5'd0) && bus.id_valid_i &&
           ((bus.id_use_rs1_i && bus.id_rs1_i == m.rd) || (bus.id_use_rs2_i && bus.id_rs2_i == m.rd));
  endfunction

  function automatic logic model_stall();
    return !rst && !bus.flush_i && (bus.hold_i || model_lu());
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic step();
    ex_t  nxt;
    logic lu, st;
    lu = model_lu();
    st = model_stall();
    nxt = m;
    if (rst || bus.flush_i) nxt = '0;
    else if (bus.hold_i) nxt = m;
    else if (lu) nxt = '0;
    else nxt = '{bus.id_valid_i, bus.id_pc_i, bus.id_rs1_i, bus.id_rs2_i, bus.id_rd_i,
                 bus.id_rdata1_i, bus.id_rdata2_i, bus.id_imm_i,
                 bus.id_valid_i ? bus.id_ctrl_i : 8'h00};
    if (rst) begin
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end else begin
      if (st) m_stall = sat_inc(m_stall);
      if (!bus.flush_i && !bus.hold_i && lu) m_bubble = sat_inc(m_bubble);
      if (bus.flush_i) m_flush = sat_inc(m_flush);
    end
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                        input logic u1, u2, input logic [31:0] d1, d2, imm, input logic [7:0] ctrl);
    bus.id_valid_i = v;   bus.id_pc_i = pc;
    bus.id_rs1_i = rs1;   bus.id_rs2_i = rs2;   bus.id_rd_i = rd;
    bus.id_use_rs1_i = u1; bus.id_use_rs2_i = u2;
    bus.id_rdata1_i = d1; bus.id_rdata2_i = d2; bus.id_imm_i = imm;
    bus.id_ctrl_i = ctrl;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.flush_i = 1'b0; bus.hold_i = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd11, 32'd22, 32'd33, C_ALU);
    do_reset();
    checks++;
    if (dut_ex() !== ex_t'(0)) begin
      failures++; $display("FAIL reset_ex got=%h exp=0", dut_ex());
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o);
    end
  endtask

  task automatic test_plain_flow();
    do_reset();
    set_id(1'b1, 32'h100, 5'd2, 5'd3, 5'd5, 1'b1, 1'b1, 32'd120, 32'd2, 32'd0, C_ALU);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL plain_stall_pre got=%b exp=0", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_rdata1_o !== 32'd120 || bus.ex_rdata2_o !== 32'd2 || bus.ex_rd_o !== 5'd5 ||
        bus.ex_valid_o !== 1'b1 || bus.ex_ctrl_o !== C_ALU) begin
      failures++;
      $display("FAIL plain_ex got=d1:%0d d2:%0d rd:%0d v:%b ctrl:%h exp=d1:120 d2:2 rd:5 v:1 ctrl:01",
               bus.ex_rdata1_o, bus.ex_rdata2_o, bus.ex_rd_o, bus.ex_valid_o, bus.ex_ctrl_o);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL plain_stall_post got=%b exp=0", bus.stall_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 32'd1000, 32'd0, 32'd4, C_LW);
    step();
    set_id(1'b1, 32'h204, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 32'd0, 32'd9, 32'd0, C_ALU);
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b exp=1", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_ctrl_o !== 8'h00 || bus.ex_valid_o !== 1'b0) begin
      failures++; $display("FAIL lu_bubble got=v:%b ctrl:%h exp=v:0 ctrl:00", bus.ex_valid_o, bus.ex_ctrl_o);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL lu_stall_once got=%b exp=0", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd8 || bus.ex_pc_o !== 32'h204 || bus.ex_ctrl_o !== C_ALU) begin
      failures++;
      $display("FAIL lu_dep_enter got=v:%b rd:%0d pc:%h ctrl:%h exp=v:1 rd:8 pc:204 ctrl:01",
               bus.ex_valid_o, bus.ex_rd_o, bus.ex_pc_o, bus.ex_ctrl_o);
    end
`ifdef ID_EX_STATS_EN
    checks++;
    if (bus.stat_bubble_o !== 32'd1 || bus.stat_stall_o !== 32'd1) begin
      failures++; $display("FAIL lu_stats got=bubble:%0d stall:%0d exp=1 1", bus.stat_bubble_o, bus.stat_stall_o);
    end
`endif
  endtask

  task automatic test_no_false_stall();
    do_reset();
    set_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, C_LW);
    step();
    set_id(1'b1, 32'h304, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, C_ALU);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL x0_stall got=%b exp=0", bus.stall_o);
    end
    set_id(1'b1, 32'h308, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0, 32'd0, 32'd8, C_LW);
    step();
    set_id(1'b1, 32'h30C, 5'd1, 5'd7, 5'd4, 1'b1, 1'b0, 32'd5, 32'd0, 32'd3, 8'h11);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL unused_rs2_stall got=%b exp=0", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_valid_o !== 1'b1 || bus.ex_pc_o !== 32'h30C) begin
      failures++; $display("FAIL unused_rs2_enter got=v:%b pc:%h exp=v:1 pc:30c", bus.ex_valid_o, bus.ex_pc_o);
    end
  endtask

  task automatic test_flush_priority();
    do_reset();
    set_id(1'b1, 32'h400, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, C_LW);
    step();
    set_id(1'b1, 32'h404, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, 32'd1, 32'd2, 32'd3, C_ALU);
    bus.hold_i = 1'b1; bus.flush_i = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall_o);
    end
    step();
    bus.hold_i = 1'b0; bus.flush_i = 1'b0;
    checks++;
    if (bus.ex_valid_o !== 1'b0 || bus.ex_ctrl_o !== 8'h00) begin
      failures++; $display("FAIL flush_bubble got=v:%b ctrl:%h exp=v:0 ctrl:00", bus.ex_valid_o, bus.ex_ctrl_o);
    end
`ifdef ID_EX_STATS_EN
    checks++;
    if (bus.stat_flush_o !== 32'd1 || bus.stat_stall_o !== 32'd0) begin
      failures++; $display("FAIL flush_stats got=flush:%0d stall:%0d exp=1 0", bus.stat_flush_o, bus.stat_stall_o);
    end
`endif
  endtask

  task automatic test_hold();
    do_reset();
    set_id(1'b1, 32'h500, 5'd4, 5'd6, 5'd9, 1'b1, 1'b1, 32'hAAAA, 32'hBBBB, 32'h0, C_ALU);
    step();
    set_id(1'b1, 32'h504, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 8'h05);
    bus.hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.stall_o !== 1'b1) begin
        failures++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, bus.stall_o);
      end
      step();
      checks++;
      if (bus.ex_rd_o !== 5'd9 || bus.ex_pc_o !== 32'h500 || bus.ex_rdata1_o !== 32'hAAAA || bus.ex_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL hold_freeze[%0d] got=rd:%0d pc:%h d1:%h v:%b exp=rd:9 pc:500 d1:aaaa v:1",
                 i, bus.ex_rd_o, bus.ex_pc_o, bus.ex_rdata1_o, bus.ex_valid_o);
      end
    end
    bus.hold_i = 1'b0;
`ifdef ID_EX_STATS_EN
    checks++;
    if (bus.stat_stall_o !== 32'd3) begin
      failures++; $display("FAIL hold_stat got=%0d exp=3", bus.stat_stall_o);
    end
`endif
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 32'h600, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, C_LW);
    step();
    set_id(1'b1, 32'h604, 5'd3, 5'd7, 5'd8, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, C_ALU);
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre got=%b exp=1", bus.stall_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_stall got=%b exp=0", bus.stall_o);
    end
    step();
    rst = 1'b0;
    checks++;
    if (dut_ex() !== ex_t'(0)) begin
      failures++; $display("FAIL rst_mid_ex got=%h exp=0", dut_ex());
    end
`ifdef ID_EX_STATS_EN
    checks++;
    if (bus.stat_stall_o !== 0 || bus.stat_bubble_o !== 0 || bus.stat_flush_o !== 0) begin
      failures++; $display("FAIL rst_mid_stats got=%0d/%0d/%0d exp=0/0/0",
                           bus.stat_stall_o, bus.stat_bubble_o, bus.stat_flush_o);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_id($urandom_range(0, 5) != 0, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             ($urandom_range(0, 1) != 0) ? (8'($urandom) | 8'h02) : 8'($urandom));
      bus.flush_i = ($urandom_range(0, 7) == 0);
      bus.hold_i  = ($urandom_range(0, 5) == 0);
      rst         = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (bus.stall_o !== model_stall()) begin
        failures++; $display("FAIL rand_stall[%0d] got=%b exp=%b", i, bus.stall_o, model_stall());
      end
      step();
      checks++;
      if (dut_ex() !== m) begin
        failures++; $display("FAIL rand_ex[%0d] got=%h exp=%h", i, dut_ex(), m);
      end
`ifdef ID_EX_STATS_EN
      checks++;
      if (bus.stat_stall_o !== m_stall || bus.stat_bubble_o !== m_bubble || bus.stat_flush_o !== m_flush) begin
        failures++; $display("FAIL rand_stats[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                             bus.stat_stall_o, bus.stat_bubble_o, bus.stat_flush_o, m_stall, m_bubble, m_flush);
      end
`endif
    end
    rst = 1'b0; bus.flush_i = 1'b0; bus.hold_i = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    m = '0; m_stall = 0; m_bubble = 0; m_flush = 0;
    rst = 1'b1; bus.flush_i = 1'b0; bus.hold_i = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h00);
    @(posedge clk);
    #1;
    test_reset();
    test_plain_flow();
    test_load_use();
    test_no_false_stall();
    test_flush_priority();
    test_hold();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
